// File: rtl/mbf_chk_pkg.sv
// Shared types and width helpers for the MBF golden-stream checker.
// The enum gives the checker FSM states; the functions derive port widths.
package mbf_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } chk_state_e;

  function automatic int idx_width(input int n_exp);
    return $clog2(n_exp + 1);
  endfunction

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mbf_chk_lane.sv
// One checked channel: sample index, saturating pass/error counters,
// completion and sticky overrun flags, plus a per-cycle mismatch strobe.
module mbf_chk_lane
  import mbf_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_EXP  = 527,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = idx_width(N_EXP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              accept,
  output logic              mismatch,
  output logic [IDX_W-1:0]  idx,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              ch_done,
  output logic              overrun
);

  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] pass_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic             ch_done_reg;
  logic             overrun_reg;

  assign accept   = run && in_valid && !ch_done_reg;
  assign mismatch = accept && (in_data != exp_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg      <= '0;
      pass_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      ch_done_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (clear) begin
      idx_reg      <= '0;
      pass_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      ch_done_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (accept) begin
        idx_reg <= idx_reg + 1'b1;
        if (mismatch) begin
          if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
        end else begin
          if (pass_cnt_reg != '1) pass_cnt_reg <= pass_cnt_reg + 1'b1;
        end
        if (idx_reg == IDX_W'(N_EXP - 1)) ch_done_reg <= 1'b1;
      end
      // Samples arriving after completion are dropped but remembered.
      if (run && in_valid && ch_done_reg) overrun_reg <= 1'b1;
    end
  end

  assign idx      = idx_reg;
  assign pass_cnt = pass_cnt_reg;
  assign err_cnt  = err_cnt_reg;
  assign ch_done  = ch_done_reg;
  assign overrun  = overrun_reg;

endmodule

// File: rtl/mbf_stream_checker.sv
// Multi-channel golden-stream checker: per-channel lanes, verdict FSM,
// idle/timeout counter and lowest-channel-wins first-mismatch capture.
module mbf_stream_checker
  import mbf_chk_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int DATA_W         = 8,
  parameter int N_EXP          = 527,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_W          = idx_width(N_EXP)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH*IDX_W-1:0]    exp_addr,
  input  logic [NUM_CH*DATA_W-1:0]   exp_data,
  output logic [NUM_CH*CNT_W-1:0]    pass_cnt,
  output logic [NUM_CH*CNT_W-1:0]    err_cnt,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          overrun,
  output logic                       first_err_vld,
  output logic [ch_width(NUM_CH)-1:0] first_err_ch,
  output logic [IDX_W-1:0]           first_err_idx,
  output logic [DATA_W-1:0]          first_err_got,
  output logic [DATA_W-1:0]          first_err_exp,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  chk_state_e       state_reg, state_next;
  logic [TO_W-1:0]  idle_cnt_reg;
  logic             clear, run;
  logic [NUM_CH-1:0] accept, mismatch, err_any;
  logic [IDX_W-1:0] idx_arr [NUM_CH];

  logic              first_err_vld_reg;
  logic [CH_W-1:0]   first_err_ch_reg;
  logic [IDX_W-1:0]  first_err_idx_reg;
  logic [DATA_W-1:0] first_err_got_reg, first_err_exp_reg;

  assign run = (state_reg == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      mbf_chk_lane #(
        .DATA_W (DATA_W),
        .N_EXP  (N_EXP),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .run      (run),
        .in_valid (in_valid[gi]),
        .in_data  (in_data[gi*DATA_W +: DATA_W]),
        .exp_data (exp_data[gi*DATA_W +: DATA_W]),
        .accept   (accept[gi]),
        .mismatch (mismatch[gi]),
        .idx      (idx_arr[gi]),
        .pass_cnt (pass_cnt[gi*CNT_W +: CNT_W]),
        .err_cnt  (err_cnt[gi*CNT_W +: CNT_W]),
        .ch_done  (ch_done[gi]),
        .overrun  (overrun[gi])
      );
      assign exp_addr[gi*IDX_W +: IDX_W] = idx_arr[gi];
      assign err_any[gi] = |err_cnt[gi*CNT_W +: CNT_W];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (&ch_done)
          state_next = (|err_any) ? ST_FAIL : ST_PASS;
        else if (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES) && !(|accept))
          state_next = ST_TIMEOUT;
      end
      default: begin
        if (start) begin
          state_next = ST_RUN;
          clear      = 1'b1;
        end
      end
    endcase
  end

  // Descending scan so the lowest mismatching channel is the one kept.
  logic              err_hit;
  logic [CH_W-1:0]   err_ch;
  logic [IDX_W-1:0]  err_idx;
  logic [DATA_W-1:0] err_got, err_exp;

  always_comb begin
    err_hit = 1'b0;
    err_ch  = '0;
    err_idx = '0;
    err_got = '0;
    err_exp = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mismatch[c]) begin
        err_hit = 1'b1;
        err_ch  = CH_W'(c);
        err_idx = idx_arr[c];
        err_got = in_data[c*DATA_W +: DATA_W];
        err_exp = exp_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      idle_cnt_reg      <= '0;
      first_err_vld_reg <= 1'b0;
      first_err_ch_reg  <= '0;
      first_err_idx_reg <= '0;
      first_err_got_reg <= '0;
      first_err_exp_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (clear || (run && |accept))
        idle_cnt_reg <= '0;
      else if (run && idle_cnt_reg != TO_W'(TIMEOUT_CYCLES))
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      if (clear) begin
        first_err_vld_reg <= 1'b0;
        first_err_ch_reg  <= '0;
        first_err_idx_reg <= '0;
        first_err_got_reg <= '0;
        first_err_exp_reg <= '0;
      end else if (err_hit && !first_err_vld_reg) begin
        first_err_vld_reg <= 1'b1;
        first_err_ch_reg  <= err_ch;
        first_err_idx_reg <= err_idx;
        first_err_got_reg <= err_got;
        first_err_exp_reg <= err_exp;
      end
    end
  end

  assign first_err_vld = first_err_vld_reg;
  assign first_err_ch  = first_err_ch_reg;
  assign first_err_idx = first_err_idx_reg;
  assign first_err_got = first_err_got_reg;
  assign first_err_exp = first_err_exp_reg;

  assign busy    = (state_reg == ST_RUN);
  assign pass    = (state_reg == ST_PASS);
  assign fail    = (state_reg == ST_FAIL);
  assign timeout = (state_reg == ST_TIMEOUT);

endmodule

// File: tb/tb_mbf_stream_checker.sv
// Scoreboard bench: scenarios queue their expected verdict snapshot, and a
// monitor per checker instance pops and compares when a verdict appears.
module tb_mbf_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, start_s;
  logic [1:0]  in_valid, in_valid_s;
  logic [15:0] in_data, in_data_s, exp_data, exp_data_s;
  logic [5:0]  exp_addr, exp_addr_s;
  logic [31:0] pass_cnt, err_cnt;
  logic [3:0]  pass_cnt_s, err_cnt_s;
  logic [1:0]  ch_done, overrun, ch_done_s, overrun_s;
  logic        first_err_vld, first_err_vld_s;
  logic [0:0]  first_err_ch, first_err_ch_s;
  logic [2:0]  first_err_idx, first_err_idx_s;
  logic [7:0]  first_err_got, first_err_exp, first_err_got_s, first_err_exp_s;
  logic        busy, pass, fail, timeout;
  logic        busy_s, pass_s, fail_s, timeout_s;

  mbf_stream_checker #(
    .NUM_CH(2), .DATA_W(8), .N_EXP(4), .CNT_W(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .exp_addr(exp_addr), .exp_data(exp_data), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .ch_done(ch_done), .overrun(overrun), .first_err_vld(first_err_vld),
    .first_err_ch(first_err_ch), .first_err_idx(first_err_idx),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout)
  );

  mbf_stream_checker #(
    .NUM_CH(2), .DATA_W(8), .N_EXP(6), .CNT_W(2), .TIMEOUT_CYCLES(4096)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start_s), .in_valid(in_valid_s), .in_data(in_data_s),
    .exp_addr(exp_addr_s), .exp_data(exp_data_s), .pass_cnt(pass_cnt_s), .err_cnt(err_cnt_s),
    .ch_done(ch_done_s), .overrun(overrun_s), .first_err_vld(first_err_vld_s),
    .first_err_ch(first_err_ch_s), .first_err_idx(first_err_idx_s),
    .first_err_got(first_err_got_s), .first_err_exp(first_err_exp_s),
    .busy(busy_s), .pass(pass_s), .fail(fail_s), .timeout(timeout_s)
  );

  // Golden memory: sample k of every channel is 10*(k+1).
  function automatic logic [7:0] exp_val(input logic [2:0] a);
    return 8'(10 * (int'(a) + 1));
  endfunction

  assign exp_data   = {exp_val(exp_addr[5:3]),   exp_val(exp_addr[2:0])};
  assign exp_data_s = {exp_val(exp_addr_s[5:3]), exp_val(exp_addr_s[2:0])};

  typedef struct {
    string       tag;
    logic        pass, fail, timeout;
    logic [15:0] pc0, pc1, ec0, ec1;
    logic [1:0]  ovr;
    logic        fv;
    logic [0:0]  fch;
    logic [2:0]  fidx;
    logic [7:0]  fgot, fexp;
    int          delay;
  } snap_t;

  snap_t q[$], qs[$];
  int n_checks = 0, n_pass = 0;
  int edge_cnt = 0, last_acc_edge = 0;
  logic prev_busy = 1'b0, prev_busy_s = 1'b0;
  logic [7:0] d0 [6], d1 [6];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got=%0h want=%0h", name, got, want);
    else n_pass++;
  endtask

  task automatic check_snap(input snap_t e, input snap_t a);
    $display("verdict %s: pass=%0b fail=%0b timeout=%0b pc=%0d/%0d ec=%0d/%0d ovr=%b fe=%0b ch%0d idx%0d %h/%h delay=%0d",
             e.tag, a.pass, a.fail, a.timeout, a.pc0, a.pc1, a.ec0, a.ec1, a.ovr,
             a.fv, a.fch, a.fidx, a.fgot, a.fexp, a.delay);
    cmp({e.tag, ".pass"},    64'(a.pass),    64'(e.pass));
    cmp({e.tag, ".fail"},    64'(a.fail),    64'(e.fail));
    cmp({e.tag, ".timeout"}, 64'(a.timeout), 64'(e.timeout));
    cmp({e.tag, ".pass_cnt0"}, 64'(a.pc0), 64'(e.pc0));
    cmp({e.tag, ".pass_cnt1"}, 64'(a.pc1), 64'(e.pc1));
    cmp({e.tag, ".err_cnt0"},  64'(a.ec0), 64'(e.ec0));
    cmp({e.tag, ".err_cnt1"},  64'(a.ec1), 64'(e.ec1));
    cmp({e.tag, ".overrun"},   64'(a.ovr), 64'(e.ovr));
    cmp({e.tag, ".first_err_vld"}, 64'(a.fv),   64'(e.fv));
    cmp({e.tag, ".first_err_ch"},  64'(a.fch),  64'(e.fch));
    cmp({e.tag, ".first_err_idx"}, 64'(a.fidx), 64'(e.fidx));
    cmp({e.tag, ".first_err_got"}, 64'(a.fgot), 64'(e.fgot));
    cmp({e.tag, ".first_err_exp"}, 64'(a.fexp), 64'(e.fexp));
    cmp({e.tag, ".verdict_delay"}, 64'(a.delay), 64'(e.delay));
  endtask

  // Monitor for the main instance: fires on the RUN -> verdict transition.
  always @(negedge clk) begin
    if ((pass || fail || timeout) && prev_busy) begin
      snap_t a;
      a.tag = "dut"; a.pass = pass; a.fail = fail; a.timeout = timeout;
      a.pc0 = pass_cnt[15:0]; a.pc1 = pass_cnt[31:16];
      a.ec0 = err_cnt[15:0];  a.ec1 = err_cnt[31:16];
      a.ovr = overrun; a.fv = first_err_vld; a.fch = first_err_ch;
      a.fidx = first_err_idx; a.fgot = first_err_got; a.fexp = first_err_exp;
      a.delay = edge_cnt - last_acc_edge;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_verdict got pass=%0b fail=%0b timeout=%0b required none",
                 pass, fail, timeout);
      end else check_snap(q.pop_front(), a);
    end
    prev_busy <= busy;
  end

  // Monitor for the saturation instance.
  always @(negedge clk) begin
    if ((pass_s || fail_s || timeout_s) && prev_busy_s) begin
      snap_t a;
      a.tag = "sat"; a.pass = pass_s; a.fail = fail_s; a.timeout = timeout_s;
      a.pc0 = 16'(pass_cnt_s[1:0]); a.pc1 = 16'(pass_cnt_s[3:2]);
      a.ec0 = 16'(err_cnt_s[1:0]);  a.ec1 = 16'(err_cnt_s[3:2]);
      a.ovr = overrun_s; a.fv = first_err_vld_s; a.fch = first_err_ch_s;
      a.fidx = first_err_idx_s; a.fgot = first_err_got_s; a.fexp = first_err_exp_s;
      a.delay = edge_cnt - last_acc_edge;
      if (qs.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_verdict_sat got pass=%0b fail=%0b timeout=%0b required none",
                 pass_s, fail_s, timeout_s);
      end else check_snap(qs.pop_front(), a);
    end
    prev_busy_s <= busy_s;
  end

  function automatic snap_t mk(input string tag, input logic p, input logic f, input logic t,
                               input int pc0, input int pc1, input int ec0, input int ec1,
                               input logic [1:0] ovr, input logic fv, input int fch,
                               input int fidx, input logic [7:0] fgot, input logic [7:0] fexp,
                               input int delay);
    snap_t s;
    s.tag = tag; s.pass = p; s.fail = f; s.timeout = t;
    s.pc0 = 16'(pc0); s.pc1 = 16'(pc1); s.ec0 = 16'(ec0); s.ec1 = 16'(ec1);
    s.ovr = ovr; s.fv = fv; s.fch = 1'(fch); s.fidx = 3'(fidx);
    s.fgot = fgot; s.fexp = fexp; s.delay = delay;
    return s;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load_clean();
    for (int k = 0; k < 6; k++) begin
      d0[k] = exp_val(3'(k));
      d1[k] = exp_val(3'(k));
    end
  endtask

  task automatic drive_streams(input int n0, input int n1, input int skew);
    int total;
    total = (n0 > n1 + skew) ? n0 : n1 + skew;
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      in_valid = 2'b00;
      if (t < n0) begin in_valid[0] = 1'b1; in_data[7:0] = d0[t]; end
      if (t >= skew && t - skew < n1) begin in_valid[1] = 1'b1; in_data[15:8] = d1[t-skew]; end
      if (in_valid != 2'b00) last_acc_edge = edge_cnt + 1;
    end
    @(negedge clk);
    in_valid = 2'b00;
  endtask

  task automatic wait_verdict(input bit sat, input int budget);
    int n;
    n = 0;
    while (!(sat ? (pass_s | fail_s | timeout_s) : (pass | fail | timeout)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      $display("FAIL verdict_wait got no verdict within %0d cycles required a verdict", budget);
      if (sat) qs.delete(); else q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    in_valid = '0; in_data = '0; in_valid_s = '0; in_data_s = '0;
    repeat (2) @(negedge clk);
    cmp("reset.busy",     64'({busy, pass, fail, timeout}), 64'd0);
    cmp("reset.exp_addr", 64'(exp_addr), 64'd0);
    cmp("reset.counts",   64'({pass_cnt, err_cnt}), 64'd0);
    cmp("reset.flags",    64'({ch_done, overrun, first_err_vld}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Clean streams, ch1 lagging ch0 by two cycles.
    load_clean();
    q.push_back(mk("clean_skew", 1, 0, 0, 4, 4, 0, 0, 2'b00, 0, 0, 0, 8'h00, 8'h00, 1));
    pulse_start();
    drive_streams(4, 4, 2);
    wait_verdict(0, 40);

    // Same-cycle mismatch on both channels at index 2: ch0 is reported.
    load_clean();
    d0[2] = 8'h00; d1[2] = 8'h33;
    q.push_back(mk("dual_mismatch", 0, 1, 0, 3, 3, 1, 1, 2'b00, 1, 0, 2, 8'h00, 8'h1E, 1));
    pulse_start();
    drive_streams(4, 4, 0);
    wait_verdict(0, 40);

    // ch0 stalls after two samples: timeout 17 edges after the last accept.
    load_clean();
    q.push_back(mk("stall", 0, 0, 1, 2, 4, 0, 0, 2'b00, 0, 0, 0, 8'h00, 8'h00, 17));
    pulse_start();
    drive_streams(2, 4, 0);
    wait_verdict(0, 60);

    // Fifth ch0 sample while ch1 is still running sets overrun only.
    load_clean();
    d0[4] = 8'h55;
    q.push_back(mk("overrun", 1, 0, 0, 4, 4, 0, 0, 2'b01, 0, 0, 0, 8'h00, 8'h00, 1));
    pulse_start();
    drive_streams(5, 4, 2);
    wait_verdict(0, 40);

    // Reset mid-run clears everything without waiting for a clock edge.
    load_clean();
    pulse_start();
    drive_streams(2, 2, 0);
    #2 reset = 1'b1;
    #1;
    cmp("midreset.state",    64'({busy, pass, fail, timeout}), 64'd0);
    cmp("midreset.exp_addr", 64'(exp_addr), 64'd0);
    cmp("midreset.counts",   64'({pass_cnt, err_cnt}), 64'd0);
    cmp("midreset.flags",    64'({ch_done, overrun, first_err_vld}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    q.push_back(mk("after_reset", 1, 0, 0, 4, 4, 0, 0, 2'b00, 0, 0, 0, 8'h00, 8'h00, 1));
    pulse_start();
    drive_streams(4, 4, 0);
    wait_verdict(0, 40);

    // Narrow counters: six mismatches per channel saturate at 3.
    qs.push_back(mk("saturate", 0, 1, 0, 0, 0, 3, 3, 2'b00, 1, 0, 0, 8'hF5, 8'h0A, 1));
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      in_valid_s = 2'b11;
      in_data_s  = {~exp_val(3'(t)), ~exp_val(3'(t))};
      last_acc_edge = edge_cnt + 1;
    end
    @(negedge clk);
    in_valid_s = 2'b00;
    wait_verdict(1, 40);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
